// File: rtl/flappy_pkg.sv
// Shared constants, types and helpers for the flappy-bird datapath.
// Geometry, pipe constants, LFSR parameters and the pipe FSM state enum.
package flappy_pkg;

    localparam int SCREEN_W      = 640;
    localparam int Y_MIN         = 0;
    localparam int ACTIVE_HEIGHT = 480;
    localparam int GROUND_H      = 0;

    localparam int BIRD_X   = 100;
    localparam int SPRITE_W = 24;
    localparam int SPRITE_H = 24;

    localparam int PIPE_W       = 52;
    localparam int GAP_H        = 120;
    localparam int GAP_MARGIN   = 40;
    localparam int PIPE_SPACING = 220;
    localparam int NUM_PIPES    = 3;
    localparam int SCROLL_SPEED = 2;

    // Span of legal gap offsets below the top margin; must be at least 128.
    localparam int GAP_RANGE = ACTIVE_HEIGHT - GROUND_H - GAP_H - 2 * GAP_MARGIN;
    localparam logic [9:0] GAP_CENTER = 10'(Y_MIN + GAP_MARGIN + GAP_RANGE / 2);

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: taps on bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef logic signed [11:0] coord_t;

    typedef enum logic [1:0] {
        PS_IDLE   = 2'd0,
        PS_RUN    = 2'd1,
        PS_FROZEN = 2'd2
    } pipe_state_e;

    function automatic coord_t to_coord(input logic [9:0] v);
        return coord_t'({2'b00, v});
    endfunction

    function automatic logic [9:0] gap_from_lfsr(input logic [7:0] r);
        logic [9:0] off;
        off = {2'b00, r};
        if (off >= 10'(GAP_RANGE)) begin
            off = off - 10'(GAP_RANGE);
        end
        return 10'(Y_MIN + GAP_MARGIN) + off;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR that advances only when en is high; reset reloads the seed.
module lfsr8
    import flappy_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe generator with bird/pipe hit detection, scoring and a per-pixel
// pipe query for the renderer. Pipes advance once per wrap of the free-running tick.
module pipe_field
    import flappy_pkg::*;
#(
    parameter int TICK_BITS = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alive,
    input  logic [9:0]         bird_y,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    output logic               collision,
    output logic [7:0]         score,
    output logic               pipe_px,
    output pipe_state_e        dbg_state_o,
    output logic signed [11:0] dbg_x0_o,
    output logic [9:0]         dbg_gap0_o
);

    localparam coord_t C_PIPE_W   = coord_t'(PIPE_W);
    localparam coord_t C_SCROLL   = coord_t'(SCROLL_SPEED);
    localparam coord_t C_WRAP     = coord_t'(NUM_PIPES * PIPE_SPACING);
    localparam coord_t C_BIRD_X   = coord_t'(BIRD_X);
    localparam coord_t C_BIRD_END = coord_t'(BIRD_X + SPRITE_W);
    localparam coord_t C_SPRITE_H = coord_t'(SPRITE_H);
    localparam coord_t C_GAP_H    = coord_t'(GAP_H);
    localparam coord_t C_Y_MIN    = coord_t'(Y_MIN);
    localparam coord_t C_Y_END    = coord_t'(Y_MIN + ACTIVE_HEIGHT - GROUND_H);
    localparam logic [TICK_BITS-1:0] TICK_ONE = TICK_BITS'(1);

    // Not cleared by reset so the step stays phase-aligned with the physics stage.
    logic [TICK_BITS-1:0] tick_q = '0;
    logic                 step;

    pipe_state_e state_q, state_d;

    logic [7:0] lfsr_q;
    logic [9:0] spawn_gap;

    coord_t by_s, px_s, py_s;

    logic [NUM_PIPES-1:0] hit;
    logic [NUM_PIPES-1:0] pix_on;
    logic [NUM_PIPES-1:0] pass;

    logic       collision_q, collision_d;
    logic [7:0] score_q, score_d;
    logic       pipe_px_q, pipe_px_d;

    always_ff @(posedge clk) begin
        tick_q <= tick_q + TICK_ONE;
    end

    assign step = (tick_q == '0);

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (step),
        .q     (lfsr_q)
    );

    assign spawn_gap = gap_from_lfsr(lfsr_q);

    assign by_s = to_coord(bird_y);
    assign px_s = to_coord(pix_x);
    assign py_s = to_coord(pix_y);

    always_comb begin
        state_d = state_q;
        case (state_q)
            PS_IDLE:   if (alive)  state_d = PS_RUN;
            PS_RUN:    if (!alive) state_d = PS_FROZEN;
            PS_FROZEN: state_d = PS_FROZEN;
            default:   state_d = PS_IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_slot
        localparam coord_t X_INIT = coord_t'(SCREEN_W + i * PIPE_SPACING);

        coord_t     x_q, x_d, nx, gap_s;
        logic [9:0] gap_q, gap_d;

        always_comb begin
            nx    = x_q - C_SCROLL;
            gap_s = to_coord(gap_q);
            x_d   = x_q;
            gap_d = gap_q;
            if (state_q == PS_IDLE) begin
                x_d   = X_INIT;
                gap_d = GAP_CENTER;
            end else if (state_q == PS_RUN && step) begin
                if (nx <= -C_PIPE_W) begin
                    x_d   = nx + C_WRAP;
                    gap_d = spawn_gap;
                end else begin
                    x_d = nx;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                x_q   <= X_INIT;
                gap_q <= GAP_CENTER;
            end else begin
                x_q   <= x_d;
                gap_q <= gap_d;
            end
        end

        assign hit[i] = (x_q < C_BIRD_END) && (x_q + C_PIPE_W > C_BIRD_X) &&
                        ((by_s < gap_s) || (by_s + C_SPRITE_H > gap_s + C_GAP_H));

        assign pix_on[i] = (x_q <= px_s) && (px_s < x_q + C_PIPE_W) &&
                           (py_s >= C_Y_MIN) && (py_s < C_Y_END) &&
                           ((py_s < gap_s) || (py_s >= gap_s + C_GAP_H));

        // Trailing edge crosses the bird column on this step.
        assign pass[i] = (state_q == PS_RUN) && step &&
                         (x_q + C_PIPE_W > C_BIRD_X) && (nx + C_PIPE_W <= C_BIRD_X);
    end

    always_comb begin
        score_d = score_q;
        if ((|pass) && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
        end
    end

    // Gating on alive makes collision drop on the first edge after alive falls.
    assign collision_d = (state_q == PS_RUN && alive) ? (|hit) : 1'b0;
    assign pipe_px_d   = |pix_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PS_IDLE;
            collision_q <= 1'b0;
            score_q     <= 8'd0;
            pipe_px_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            collision_q <= collision_d;
            score_q     <= score_d;
            pipe_px_q   <= pipe_px_d;
        end
    end

    assign collision   = collision_q;
    assign score       = score_q;
    assign pipe_px     = pipe_px_q;
    assign dbg_state_o = state_q;
    assign dbg_x0_o    = g_slot[0].x_q;
    assign dbg_gap0_o  = g_slot[0].gap_q;

endmodule

// File: tb/tb_pipe_field.sv
// Directed bench for pipe_field with a 16-clock step (TICK_BITS=4).
module tb_pipe_field;
    import flappy_pkg::*;

    localparam int STEP_CLKS = 16;

    logic clk = 1'b0;
    logic reset;
    logic alive;
    logic [9:0] bird_y;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic collision;
    logic [7:0] score;
    logic pipe_px;
    pipe_state_e dbg_state;
    logic signed [11:0] dbg_x0;
    logic [9:0] dbg_gap0;

    int n_check = 0;
    int n_bad   = 0;
    int n_edge  = 0;
    int n_step  = 0;
    logic [7:0] lfsr_m;
    logic [7:0] lfsr_at_step;

    always #5 clk = ~clk;

    pipe_field #(.TICK_BITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .alive       (alive),
        .bird_y      (bird_y),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .collision   (collision),
        .score       (score),
        .pipe_px     (pipe_px),
        .dbg_state_o (dbg_state),
        .dbg_x0_o    (dbg_x0),
        .dbg_gap0_o  (dbg_gap0)
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    endfunction

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock edge; tracks step phase and the reference LFSR, then settles.
    task automatic cyc();
        @(posedge clk);
        if (reset) begin
            lfsr_m = 8'hA5;
        end else if (n_edge % STEP_CLKS == 0) begin
            lfsr_at_step = lfsr_m;
            lfsr_m = lfsr_next(lfsr_m);
        end
        if (n_edge % STEP_CLKS == 0) n_step++;
        n_edge++;
        #1;
    endtask

    task automatic wait_steps(input int n);
        int target;
        target = n_step + n;
        while (n_step < target) cyc();
    endtask

    task automatic query(input int x, input int y, input logic exp, input string tag);
        pix_x = 10'(x);
        pix_y = 10'(y);
        cyc();
        check(tag, pipe_px, exp);
    endtask

    task automatic bird(input int y, input logic exp, input string tag);
        bird_y = 10'(y);
        cyc();
        check(tag, collision, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        alive  = 1'b0;
        bird_y = 10'd200;
        pix_x  = 10'd0;
        pix_y  = 10'd0;
        repeat (3) cyc();
        reset = 1'b0;

        check("rst_state", dbg_state, PS_IDLE);
        check("rst_coll", collision, 0);
        check("rst_score", score, 0);
        check("rst_pix", pipe_px, 0);
        check("rst_x0", dbg_x0, 640);
        check("rst_gap0", dbg_gap0, 180);

        wait_steps(3);
        check("idle_x0", dbg_x0, 640);
        check("idle_gap0", dbg_gap0, 180);
        check("idle_score", score, 0);
        check("idle_state", dbg_state, PS_IDLE);
        query(640, 10, 1'b1, "idle_pix_s0_left");
        query(639, 10, 1'b0, "idle_pix_s0_before");
        query(860, 10, 1'b1, "idle_pix_s1_left");
        query(912, 10, 1'b0, "idle_pix_s1_after");

        wait_steps(1);
        alive = 1'b1;
        cyc();
        check("run_state", dbg_state, PS_RUN);

        wait_steps(100);
        check("run100_x0", dbg_x0, 440);
        check("run100_gap0", dbg_gap0, 180);

        wait_steps(160);
        check("run260_x0", dbg_x0, 120);
        bird(20, 1'b1, "coll_above_gap");
        bird(200, 1'b0, "coll_in_gap");
        bird(276, 1'b0, "coll_gap_bottom_edge");
        bird(277, 1'b1, "coll_below_gap");
        bird(180, 1'b0, "coll_gap_top_edge");
        bird(179, 1'b1, "coll_above_by_one");
        bird_y = 10'd200;
        query(121, 10, 1'b1, "pix_body_top");
        query(121, 200, 1'b0, "pix_in_gap");
        query(172, 10, 1'b0, "pix_right_edge");
        query(120, 10, 1'b1, "pix_left_edge");
        query(121, 479, 1'b1, "pix_last_row");
        query(121, 480, 1'b0, "pix_below_field");

        wait_steps(35);
        check("step295_score", score, 0);
        wait_steps(1);
        check("step296_score", score, 1);
        check("step296_x0", dbg_x0, 48);
        wait_steps(49);
        check("step345_x0", dbg_x0, -50);
        check("step345_score", score, 1);
        wait_steps(1);
        check("respawn_x0", dbg_x0, 608);
        check("respawn_gap0", dbg_gap0, 40 + int'(lfsr_at_step));

        wait_steps(54);
        check("step400_x0", dbg_x0, 500);
        bird(20, 1'b1, "coll_slot1");
        alive = 1'b0;
        cyc();
        check("frz_coll_drop", collision, 0);
        check("frz_state", dbg_state, PS_FROZEN);
        wait_steps(5);
        check("frz_x0", dbg_x0, 500);
        check("frz_score", score, 1);
        check("frz_coll", collision, 0);
        query(501, 10, 1'b1, "frz_pix");

        reset = 1'b1;
        alive = 1'b1;
        cyc();
        reset = 1'b0;
        alive = 1'b0;
        check("rst2_state", dbg_state, PS_IDLE);
        check("rst2_x0", dbg_x0, 640);
        check("rst2_gap0", dbg_gap0, 180);
        check("rst2_score", score, 0);
        check("rst2_coll", collision, 0);
        cyc();
        check("rst2_hold_idle", dbg_state, PS_IDLE);

        $display("test done: total=%0d bad=%0d", n_check, n_bad);
        $finish;
    end

endmodule
